// File: rtl/iobuf_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// iobuf_ctrl_pkg
//   Shared definitions for the half-duplex IOBUF controller: the 3-bit state
//   encoding and helpers that size the shared down-counter from the
//   timing parameters.
// ---------------------------------------------------------------------------
package iobuf_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DRIVE   = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_TURN    = 3'd3;
  localparam logic [2:0] ST_SAMPLE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    DRIVE   = ST_DRIVE,
    RELEASE = ST_RELEASE,
    TURN    = ST_TURN,
    SAMPLE  = ST_SAMPLE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width able to hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/io_sync.sv
// ---------------------------------------------------------------------------
// io_sync
//   Multi-flop vector synchronizer bringing the asynchronous pad input word
//   into the clk domain. Bits are synchronized independently; callers only
//   consume the output while the pad word is known to be stable.
// Ports
//   clk    in  1      sampling clock
//   rst_n  in  1      asynchronous active-low reset, clears every stage
//   d      in  WIDTH  asynchronous input word
//   q      out WIDTH  synchronized word (last stage)
// ---------------------------------------------------------------------------
module io_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // NOTE: non-blocking assignments here so every stage captures the value its
  // predecessor held before the edge; blocking would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is a flop chain, not a RAM, so it is reset; a
      // storage memory would normally be left unreset.
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/iobuf_halfdup_ctrl.sv
// ---------------------------------------------------------------------------
// iobuf_halfdup_ctrl
//   Fabric-side direction sequencer for a half-duplex tri-state pad group.
//   Drives tx words onto the pads, releases the bus for a turnaround period
//   on every direction change, and captures one pad word through a
//   synchronizer per rx request. Pads are only enabled while in DRIVE, and
//   every enable flop resets asynchronously to high-Z.
// Ports
//   CLK       in  1      clock, rising edge
//   RST_N     in  1      asynchronous active-low reset
//   tx_valid  in  1      tx word offered
//   tx_ready  out 1      tx_data / rx_req accepted this cycle (combinational)
//   tx_data   in  WIDTH  word to drive
//   rx_req    in  1      request one sampled pad word
//   rx_valid  out 1      one-cycle pulse, rx_data updated
//   rx_data   out WIDTH  last sampled pad word
//   busy      out 1      controller not idle
//   PAD_I     out WIDTH  IOBUF I
//   PAD_T     out WIDTH  IOBUF T, 1 = high-Z (all bits together)
//   PAD_O     in  WIDTH  IOBUF O, asynchronous to CLK
// ---------------------------------------------------------------------------
module iobuf_halfdup_ctrl
  import iobuf_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int TA_CYCLES   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             rx_req,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic [WIDTH-1:0] PAD_I,
  output logic [WIDTH-1:0] PAD_T,
  input  logic [WIDTH-1:0] PAD_O
);

  localparam int CW = cnt_w(max3(HOLD_CYCLES, TA_CYCLES, SYNC_STAGES));
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TA_LD   = CW'(TA_CYCLES - 1);
  localparam logic [CW-1:0] SYNC_LD = CW'(SYNC_STAGES - 1);

  state_t           state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             rx_pend_q,  rx_pend_d;
  logic [WIDTH-1:0] pad_t_q,    pad_t_d;
  logic [WIDTH-1:0] pad_i_q,    pad_i_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q,  rx_data_d;
  logic             busy_q,     busy_d;
  logic [WIDTH-1:0] pad_o_sync;

  io_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (PAD_O),
    .q     (pad_o_sync)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_pend_d  = rx_pend_q;
    pad_i_d    = pad_i_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;

    // Handshake point: idle, or the last cycle of a driven word.
    tx_ready = (state_q == IDLE) || ((state_q == DRIVE) && (cnt_q == '0));

    unique case (state_q)
      IDLE: begin
        // tx wins a tie; an ignored rx_req must be held by the requester.
        if (tx_valid) begin
          state_d = DRIVE;
          cnt_d   = HOLD_LD;
          pad_i_d = tx_data;
        end else if (rx_req) begin
          state_d = TURN;
          cnt_d   = TA_LD;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (tx_valid) begin
          // Back-to-back word: keep the pads enabled, no turnaround.
          cnt_d   = HOLD_LD;
          pad_i_d = tx_data;
        end else begin
          // Leaving DRIVE always passes through RELEASE; an rx accepted here
          // is remembered and taken after the bus is released.
          state_d   = RELEASE;
          cnt_d     = TA_LD;
          rx_pend_d = rx_req;
        end
      end
      RELEASE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_pend_q) begin
          state_d   = TURN;
          cnt_d     = TA_LD;
          rx_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      TURN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = SAMPLE;
          cnt_d   = SYNC_LD;
        end
      end
      SAMPLE: begin
        // Wait for the synchronizer to flush pre-turnaround pad values.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d    = IDLE;
          rx_data_d  = pad_o_sync;
          rx_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pad controls are registered from the next state, so PAD_T is low
    // exactly in the cycles the state register holds DRIVE.
    pad_t_d = (state_d == DRIVE) ? '0 : '1;
    if (state_d != DRIVE) begin
      pad_i_d = '0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_pend_q  <= 1'b0;
      pad_t_q    <= '1;
      pad_i_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_pend_q  <= rx_pend_d;
      pad_t_q    <= pad_t_d;
      pad_i_q    <= pad_i_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
    end
  end

  assign PAD_T    = pad_t_q;
  assign PAD_I    = pad_i_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;

endmodule
